// File: rtl/beta_operand_stage.sv
// beta_operand_stage
//   Operand-fetch stage in front of the Beta ALU. Reads the 32-entry register
//   file (with same-cycle writeback bypass), selects Rb or the sign-extended
//   literal, and registers A/B/ALUOp/Rc for the ALU. A per-register pending
//   scoreboard stalls readers of registers whose writeback is still in flight.
// Ports
//   clk, reset_n             clock, async active-low reset
//   in_valid/in_ready        decode handshake
//   in_alu_op, in_ra, in_rb, in_rc, in_use_lit, in_lit   decoded op fields
//   out_valid/out_ready      ALU handshake
//   out_a, out_b, out_alu_op, out_rc                     registered operands
//   wb_en, wb_rc, wb_data    ALU result write into the register file
module beta_operand_stage #(
    parameter int DATA_W   = 32,
    parameter int LIT_W    = 16,
    parameter int ZERO_REG = 31
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        in_alu_op,
    input  logic [4:0]        in_ra,
    input  logic [4:0]        in_rb,
    input  logic [4:0]        in_rc,
    input  logic              in_use_lit,
    input  logic [LIT_W-1:0]  in_lit,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_a,
    output logic [DATA_W-1:0] out_b,
    output logic [4:0]        out_alu_op,
    output logic [4:0]        out_rc,
    input  logic              wb_en,
    input  logic [4:0]        wb_rc,
    input  logic [DATA_W-1:0] wb_data
);

    localparam int         NREG = 32;
    localparam logic [4:0] ZR   = 5'(ZERO_REG);

    logic [DATA_W-1:0] rf [NREG];
    logic [NREG-1:0]   pending;
    logic [NREG-1:0]   pending_nxt;
    logic [NREG-1:0]   wb_mask;
    logic [NREG-1:0]   pend_eff;
    logic [DATA_W-1:0] rd_a;
    logic [DATA_W-1:0] rd_b;
    logic [DATA_W-1:0] sel_b;
    logic              wb_live;
    logic              hazard;
    logic              accept;

    // A write to the zero register is dropped entirely: no bypass, no clear.
    assign wb_live = wb_en && (wb_rc != ZR);
    assign wb_mask = wb_live ? (NREG'(1) << wb_rc) : '0;

    // A register being written back this cycle is not a hazard: the bypass
    // below hands the reader the value being written.
    assign pend_eff = pending & ~wb_mask;

    always_comb begin
        rd_a = '0;
        if (in_ra != ZR)
            rd_a = (wb_live && wb_rc == in_ra) ? wb_data : rf[in_ra];
    end

    always_comb begin
        rd_b = '0;
        if (in_rb != ZR)
            rd_b = (wb_live && wb_rc == in_rb) ? wb_data : rf[in_rb];
    end

    assign sel_b    = in_use_lit ? {{(DATA_W-LIT_W){in_lit[LIT_W-1]}}, in_lit} : rd_b;
    assign hazard   = pend_eff[in_ra] | (!in_use_lit & pend_eff[in_rb]);
    assign in_ready = (!out_valid | out_ready) & !hazard;
    assign accept   = in_valid & in_ready;

    // Accept sets after writeback clears, so a same-cycle new writer of the
    // retiring register leaves the bit set.
    always_comb begin
        pending_nxt = pending & ~wb_mask;
        if (accept && in_rc != ZR)
            pending_nxt[in_rc] = 1'b1;
        pending_nxt[ZR] = 1'b0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending <= '0;
            for (int i = 0; i < NREG; i++)
                rf[i] <= '0;
        end else begin
            pending <= pending_nxt;
            if (wb_live)
                rf[wb_rc] <= wb_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid  <= 1'b0;
            out_a      <= '0;
            out_b      <= '0;
            out_alu_op <= '0;
            out_rc     <= '0;
        end else if (accept) begin
            out_valid  <= 1'b1;
            out_a      <= rd_a;
            out_b      <= sel_b;
            out_alu_op <= in_alu_op;
            out_rc     <= in_rc;
        end else if (out_ready) begin
            // Drain: data regs keep their last value, only valid drops.
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_beta_operand_stage.sv
// Bench for beta_operand_stage: directed scenarios followed by a random
// phase. A reference model, updated on the falling edge, predicts in_ready
// and out_valid, and pushes the expected operand bundle into a scoreboard
// queue on every predicted accept; the front entry is compared against the
// DUT outputs whenever the model says out_valid is high.
module tb_beta_operand_stage;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  op;
        logic [4:0]  rc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  in_alu_op = '0;
    logic [4:0]  in_ra = '0;
    logic [4:0]  in_rb = '0;
    logic [4:0]  in_rc = '0;
    logic        in_use_lit = 1'b0;
    logic [15:0] in_lit = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_a;
    logic [31:0] out_b;
    logic [4:0]  out_alu_op;
    logic [4:0]  out_rc;
    logic        wb_en = 1'b0;
    logic [4:0]  wb_rc = '0;
    logic [31:0] wb_data = '0;

    int n_chk = 0;
    int n_fail = 0;

    exp_t        sb[$];
    logic [31:0] m_rf [32];
    logic [31:0] m_pend;
    logic        m_valid;

    beta_operand_stage #(.DATA_W(32), .LIT_W(16), .ZERO_REG(31)) dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_alu_op(in_alu_op), .in_ra(in_ra), .in_rb(in_rb), .in_rc(in_rc),
        .in_use_lit(in_use_lit), .in_lit(in_lit),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_a(out_a), .out_b(out_b), .out_alu_op(out_alu_op), .out_rc(out_rc),
        .wb_en(wb_en), .wb_rc(wb_rc), .wb_data(wb_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_read(input logic [4:0] r);
        if (r == 5'd31) return 32'h0;
        if (wb_en && wb_rc == r) return wb_data;
        return m_rf[r];
    endfunction

    function automatic logic m_busy(input logic [4:0] r);
        if (r == 5'd31) return 1'b0;
        if (wb_en && wb_rc == r) return 1'b0;
        return m_pend[r];
    endfunction

    // Reference model: sampled mid-cycle, predicts the next rising edge.
    always @(negedge clk) begin
        if (!reset_n) begin
            sb.delete();
            m_pend  = '0;
            m_valid = 1'b0;
            for (int i = 0; i < 32; i++) m_rf[i] = '0;
            chk("rst_out_valid", {31'b0, out_valid}, 32'h0);
        end else begin
            logic haz, rdy, acc;
            exp_t e;
            chk("out_valid", {31'b0, out_valid}, {31'b0, m_valid});
            if (m_valid) begin
                if (sb.size() == 0) begin
                    chk("sb_underflow", 32'h0, 32'h1);
                end else begin
                    chk("out_a", out_a, sb[0].a);
                    chk("out_b", out_b, sb[0].b);
                    chk("out_alu_op", {27'b0, out_alu_op}, {27'b0, sb[0].op});
                    chk("out_rc", {27'b0, out_rc}, {27'b0, sb[0].rc});
                end
            end
            haz = m_busy(in_ra) || (!in_use_lit && m_busy(in_rb));
            rdy = (!m_valid || out_ready) && !haz;
            acc = in_valid && rdy;
            if (in_valid) chk("in_ready", {31'b0, in_ready}, {31'b0, rdy});
            if (m_valid && out_ready && sb.size() > 0) void'(sb.pop_front());
            if (acc) begin
                e.a  = m_read(in_ra);
                e.b  = in_use_lit ? {{16{in_lit[15]}}, in_lit} : m_read(in_rb);
                e.op = in_alu_op;
                e.rc = in_rc;
                sb.push_back(e);
            end
            m_valid = acc ? 1'b1 : (out_ready ? 1'b0 : m_valid);
            if (wb_en && wb_rc != 5'd31) begin
                m_pend[wb_rc] = 1'b0;
                m_rf[wb_rc]   = wb_data;
            end
            if (acc && in_rc != 5'd31) m_pend[in_rc] = 1'b1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic op(input logic v, input logic [4:0] alu, input logic [4:0] ra,
                      input logic [4:0] rb, input logic [4:0] rc,
                      input logic lit_en, input logic [15:0] lit);
        in_valid = v; in_alu_op = alu; in_ra = ra; in_rb = rb; in_rc = rc;
        in_use_lit = lit_en; in_lit = lit;
    endtask

    task automatic wb(input logic en, input logic [4:0] rc, input logic [31:0] d);
        wb_en = en; wb_rc = rc; wb_data = d;
    endtask

    initial begin
        // 1: reset state, then zero-register read.
        step(); step();
        chk("rst_out_a", out_a, 32'h0);
        chk("rst_out_b", out_b, 32'h0);
        chk("rst_out_rc", {27'b0, out_rc}, 32'h0);
        reset_n = 1'b1;
        step();
        op(1, 5'h10, 31, 31, 1, 0, 16'h0);
        step();
        op(0, 0, 0, 0, 0, 0, 0);
        chk("t1_valid", {31'b0, out_valid}, 32'h1);
        chk("t1_a", out_a, 32'h0);
        chk("t1_b", out_b, 32'h0);
        step();

        // 2: writeback then literal op with negative literal.
        wb(1, 3, 32'h1234);
        step();
        wb(0, 0, 0);
        op(1, 5'h01, 3, 0, 2, 1, 16'h8000);
        step();
        op(0, 0, 0, 0, 0, 0, 0);
        chk("t2_a", out_a, 32'h0000_1234);
        chk("t2_b", out_b, 32'hFFFF_8000);
        step();

        // 3: RAW stall, released by same-cycle writeback with bypass.
        op(1, 5'h02, 31, 31, 5, 0, 0);
        step();
        op(1, 5'h03, 5, 31, 6, 0, 0);
        #1 chk("t3_stall", {31'b0, in_ready}, 32'h0);
        step();
        #1 chk("t3_stall2", {31'b0, in_ready}, 32'h0);
        step();
        wb(1, 5, 32'hA5A5_A5A5);
        #1 chk("t3_go", {31'b0, in_ready}, 32'h1);
        step();
        wb(0, 0, 0);
        op(0, 0, 0, 0, 0, 0, 0);
        chk("t3_a", out_a, 32'hA5A5_A5A5);
        step();
        wb(1, 6, 32'h66);
        step();
        wb(0, 0, 0);

        // 4: downstream backpressure holds outputs and blocks input.
        out_ready = 1'b0;
        op(1, 5'h04, 31, 31, 8, 1, 16'h0042);
        step();
        op(1, 5'h05, 31, 31, 9, 1, 16'h0077);
        for (int i = 0; i < 3; i++) begin
            #1 chk("t4_block", {31'b0, in_ready}, 32'h0);
            chk("t4_hold_b", out_b, 32'h0000_0042);
            step();
        end
        out_ready = 1'b1;
        step();
        op(0, 0, 0, 0, 0, 0, 0);
        chk("t4_new_b", out_b, 32'h0000_0077);
        step();
        wb(1, 8, 32'h8); step();
        wb(1, 9, 32'h9); step();
        wb(0, 0, 0);

        // 5: retiring writer and new writer of R7 in the same cycle.
        op(1, 5'h06, 31, 31, 7, 0, 0);
        step();
        wb(1, 7, 32'h77);
        op(1, 5'h07, 31, 31, 7, 0, 0);
        step();
        wb(0, 0, 0);
        op(1, 5'h08, 7, 31, 10, 0, 0);
        #1 chk("t5_stall", {31'b0, in_ready}, 32'h0);
        step();
        #1 chk("t5_stall2", {31'b0, in_ready}, 32'h0);
        step();
        wb(1, 7, 32'h99);
        step();
        wb(0, 0, 0);
        op(0, 0, 0, 0, 0, 0, 0);
        chk("t5_a", out_a, 32'h99);
        step();
        wb(1, 10, 32'h10); step();
        wb(0, 0, 0);

        // 6: reset while an op is held and R4 is pending.
        out_ready = 1'b0;
        op(1, 5'h09, 31, 31, 4, 0, 0);
        step();
        op(0, 0, 0, 0, 0, 0, 0);
        step();
        reset_n = 1'b0;
        #1 chk("t6_rst_valid", {31'b0, out_valid}, 32'h0);
        step();
        reset_n = 1'b1;
        out_ready = 1'b1;
        op(1, 5'h0A, 4, 31, 11, 1, 16'h0005);
        #1 chk("t6_no_stall", {31'b0, in_ready}, 32'h1);
        step();
        op(0, 0, 0, 0, 0, 0, 0);
        chk("t6_a", out_a, 32'h0);
        step();

        // Random traffic, checked by the model.
        for (int i = 0; i < 400; i++) begin
            op(($urandom_range(0, 3) != 0), 5'($urandom), 5'($urandom), 5'($urandom),
               5'($urandom), ($urandom_range(0, 1) == 1), 16'($urandom));
            wb(($urandom_range(0, 2) == 0), 5'($urandom), $urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        op(0, 0, 0, 0, 0, 0, 0);
        wb(0, 0, 0);
        out_ready = 1'b1;
        step(); step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
